// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling feeding a show-ahead receive FIFO.
// Good bytes are pushed; bad stop bits and full-FIFO drops raise one-cycle error pulses.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     baud_tick_16x,
  input  logic                     rx,
  input  logic                     rx_read,
  output logic [7:0]               rx_data_out,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rx_busy,
  output logic                     frame_err,
  output logic                     overrun_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            push_req, frame_req;

  logic            half_c, full_c;
  logic            cnt_clr_c, cnt_inc_c, shift_en_c, bit_clr_c, bit_inc_c;
  logic            push_set_c, frame_set_c;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next_c;
  logic            do_pop_c, do_push_c;
  logic [CNTW-1:0] cnt_next_c, remain_c;
  logic [7:0]      head_next_c;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign half_c = (cnt_q == CW'(OVERSAMPLE / 2 - 1));
  assign full_c = (cnt_q == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (baud_tick_16x) begin
      case (state_q)
        S_IDLE:  if (!rx_s) state_d = S_START;
        S_START: if (half_c) state_d = rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (full_c && (bit_q == 3'd7)) state_d = S_STOP;
        S_STOP:  if (full_c) state_d = rx_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rx_s) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath strobes; all sampling happens on the tick that completes a count.
  always_comb begin
    cnt_clr_c   = 1'b0;
    cnt_inc_c   = 1'b0;
    shift_en_c  = 1'b0;
    bit_clr_c   = 1'b0;
    bit_inc_c   = 1'b0;
    push_set_c  = 1'b0;
    frame_set_c = 1'b0;
    if (baud_tick_16x) begin
      case (state_q)
        S_START: begin
          if (half_c) begin
            cnt_clr_c = 1'b1;
            bit_clr_c = 1'b1;
          end else cnt_inc_c = 1'b1;
        end
        S_DATA: begin
          if (full_c) begin
            cnt_clr_c  = 1'b1;
            shift_en_c = 1'b1;
            bit_inc_c  = 1'b1;
          end else cnt_inc_c = 1'b1;
        end
        S_STOP: begin
          if (full_c) begin
            cnt_clr_c   = 1'b1;
            push_set_c  = rx_s;
            frame_set_c = !rx_s;
          end else cnt_inc_c = 1'b1;
        end
        default: cnt_clr_c = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_req  <= 1'b0;
      frame_req <= 1'b0;
    end else begin
      if (cnt_clr_c)      cnt_q <= '0;
      else if (cnt_inc_c) cnt_q <= cnt_q + CW'(1);
      if (bit_clr_c)      bit_q <= '0;
      else if (bit_inc_c) bit_q <= bit_q + 3'd1;
      if (shift_en_c)     shift_q <= {rx_s, shift_q[7:1]};
      push_req  <= push_set_c;
      frame_req <= frame_set_c;
    end
  end

  // FIFO: a pop in the push cycle frees the slot even when full.
  always_comb begin
    do_pop_c    = rx_read && !rx_empty;
    do_push_c   = push_req && (!rx_full || do_pop_c);
    cnt_next_c  = rx_count + CNTW'(do_push_c) - CNTW'(do_pop_c);
    remain_c    = rx_count - CNTW'(do_pop_c);
    rd_next_c   = rd_ptr + AW'(do_pop_c);
    head_next_c = rx_data_out;
    if (remain_c != '0) head_next_c = mem[rd_next_c];
    else if (do_push_c) head_next_c = shift_q;
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_count    <= '0;
      rx_empty    <= 1'b1;
      rx_full     <= 1'b0;
      rx_data_out <= '0;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr      <= rd_next_c;
      rx_count    <= cnt_next_c;
      rx_empty    <= (cnt_next_c == '0);
      rx_full     <= (cnt_next_c == CNTW'(DEPTH));
      rx_data_out <= head_next_c;
      rx_busy     <= (state_d != S_IDLE);
      frame_err   <= frame_req;
      overrun_err <= push_req && !do_push_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames checked against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OS    = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b1;
  logic       rx = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_empty, rx_full, rx_busy, frame_err, overrun_err;
  logic [4:0] rx_count;

  int checks = 0, failures = 0;
  int frame_seen = 0, overrun_seen = 0, exp_frame = 0, exp_overrun = 0;
  logic [7:0] model_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick_16x(tick), .rx(rx), .rx_read(rx_read),
    .rx_data_out(rx_data_out), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_count(rx_count), .rx_busy(rx_busy), .frame_err(frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)   frame_seen++;
    if (overrun_err) overrun_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [7:0] d);
    rx = 1'b0;
    cycles(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cycles(OS);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    drive_bits(d);
    rx = stop;
    cycles(OS);
    rx = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(rx_count), 32'(model_q.size()));
    check({tag, "_empty"}, 32'(rx_empty), 32'(model_q.size() == 0));
    check({tag, "_full"},  32'(rx_full),  32'(model_q.size() == DEPTH));
    if (model_q.size() > 0) check({tag, "_head"}, 32'(rx_data_out), 32'(model_q[0]));
    check({tag, "_ferr"}, 32'(frame_seen), 32'(exp_frame));
    check({tag, "_oerr"}, 32'(overrun_seen), 32'(exp_overrun));
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input string tag);
    drive_frame(d, stop);
    if (!stop) exp_frame++;
    else if (model_q.size() < DEPTH) model_q.push_back(d);
    else exp_overrun++;
    cycles(4);
    check_state(tag);
  endtask

  task automatic pop_check(input string tag);
    rx_read = 1'b1;
    if (model_q.size() > 0) check({tag, "_data"}, 32'(rx_data_out), 32'(model_q[0]));
    cycles(1);
    rx_read = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check({tag, "_cnt"}, 32'(rx_count), 32'(model_q.size()));
  endtask

  initial begin
    logic saw_busy;
    logic [7:0] d;

    // Reset values
    cycles(3);
    check("rst_empty", 32'(rx_empty), 32'd1);
    check("rst_count", 32'(rx_count), 32'd0);
    check("rst_busy",  32'(rx_busy),  32'd0);
    check("rst_data",  32'(rx_data_out), 32'd0);
    reset_n = 1'b1;
    cycles(5);

    // Single byte then drain
    send(8'hA5, 1'b1, "a5");
    pop_check("a5_rd");
    check("a5_empty", 32'(rx_empty), 32'd1);

    // False start glitch
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycles(1);
      saw_busy |= rx_busy;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("glitch_busy_end",  32'(rx_busy),  32'd0);
    check_state("glitch");

    // Bad stop followed by a long break
    drive_bits(8'h3C);
    rx = 1'b0;
    cycles(40 * OS);
    exp_frame++;
    check("brk_busy", 32'(rx_busy), 32'd1);
    check_state("brk");
    rx = 1'b1;
    cycles(6);
    check("brk_idle", 32'(rx_busy), 32'd0);
    send(8'h5A, 1'b1, "after_brk");
    pop_check("after_brk_rd");

    // Fill to full plus one overrun
    for (int b = 0; b <= 16; b++) send(8'(b), 1'b1, $sformatf("fill%0d", b));
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
    pop_check("empty_rd");
    check("empty_rd_flag", 32'(rx_empty), 32'd1);

    // Full FIFO, pop in the push cycle of 0x77
    for (int b = 0; b < 16; b++) send(8'(b), 1'b1, $sformatf("refill%0d", b));
    fork
      drive_frame(8'h77, 1'b1);
      begin
        cycles(155);
        rx_read = 1'b1;
        cycles(1);
        rx_read = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_q.push_back(8'h77);
    cycles(4);
    check_state("simul");
    check("simul_head", 32'(rx_data_out), 32'h01);
    for (int i = 0; i < 16; i++) pop_check($sformatf("simul_drain%0d", i));

    // Reset during bit 4 with three entries buffered
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1, "pre_rst");
    d = 8'hC3;
    rx = 1'b0;
    cycles(OS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      cycles(OS);
    end
    rx = d[4];
    cycles(OS / 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(rx_empty), 32'd1);
    check("mid_rst_count", 32'(rx_count), 32'd0);
    check("mid_rst_busy",  32'(rx_busy),  32'd0);
    model_q.delete();
    rx = 1'b1;
    cycles(3);
    reset_n = 1'b1;
    cycles(5);
    check_state("post_rst");
    send(8'h81, 1'b1, "post_rst_81");
    pop_check("post_rst_rd");

    // Randomized frames, bad stops, reads and gaps
    for (int n = 0; n < 30; n++) begin
      send(8'($urandom), ($urandom_range(0, 7) != 0), $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 1)) pop_check($sformatf("rnd_rd%0d", n));
      cycles($urandom_range(0, 20));
    end
    while (model_q.size() > 0) pop_check("rnd_drain");
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
